// File: rtl/control_pkg.sv
// control_pkg: shared state encodings, button indices and BCD helpers for the control sequencer
package control_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    LOADED = 3'd2,
    RUN    = 3'd3,
    PAUSE  = 3'd4,
    DONE   = 3'd5
  } state_t;
  localparam int BTN_START = 0;
  localparam int BTN_LOAD  = 1;
  localparam int BTN_SET   = 2;
  localparam int BTN_RST   = 3;
  localparam int DIGIT_W   = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [2*DIGIT_W-1:0] bcd2_t;
  function automatic digit_t clamp9(digit_t d);
    return d > DIGIT_W'(9) ? DIGIT_W'(9) : d;
  endfunction
  function automatic bcd2_t bcd_dec(bcd2_t v);
    return v[DIGIT_W-1:0] == '0 ? {v[2*DIGIT_W-1:DIGIT_W] - 1'b1, DIGIT_W'(9)} : v - 1'b1;
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: mode, buttons, switches and status outputs of the control sequencer
interface control_sequencer_if;
  import control_pkg::*;
  logic                 demoOrRealModeIn;
  logic [3:0]           resetSetLoadStartIn;
  logic [DIGIT_W-1:0]   toggleSwitches17To14In;
  logic [DIGIT_W-1:0]   toggleSwitches13To10In;
  logic [2*DIGIT_W-1:0] countValueOut;
  logic [2:0]           stateOut;
  logic                 runningOut;
  logic                 doneOut;
  modport master (
    output demoOrRealModeIn, resetSetLoadStartIn, toggleSwitches17To14In, toggleSwitches13To10In,
    input  countValueOut, stateOut, runningOut, doneOut
  );
  modport slave (
    input  demoOrRealModeIn, resetSetLoadStartIn, toggleSwitches17To14In, toggleSwitches13To10In,
    output countValueOut, stateOut, runningOut, doneOut
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-sample debouncer and single-cycle press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, stable, prev;
  logic [CW-1:0] cnt;
  // stable/prev start high so a button held through reset must be released before it can fire
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b1;
      prev   <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      prev  <= stable;
      press <= stable & ~prev;
      if (s2 == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: button-driven BCD countdown FSM with demo/real tick divider
module control_sequencer
  import control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEMO_DIV        = 5_000_000,
  parameter int REAL_DIV        = 50_000_000
) (
  input logic clkIn,
  input logic rstIn,
  control_sequencer_if.slave bus
);
  localparam int DW = $clog2((DEMO_DIV > REAL_DIV ? DEMO_DIV : REAL_DIV) + 1);
  logic [3:0] ev;
  logic rst_e, set_e, load_e, start_e;
  state_t state, state_n;
  bcd2_t set_reg, set_n, count, count_n;
  logic [DW-1:0] div, div_n, div_max;
  logic done, done_n, running;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clkIn),
      .rst(rstIn),
      .raw(bus.resetSetLoadStartIn[i]),
      .press(ev[i])
    );
  end
  // only the highest-priority event of a cycle survives
  assign rst_e   = ev[BTN_RST];
  assign set_e   = ev[BTN_SET] & ~ev[BTN_RST];
  assign load_e  = ev[BTN_LOAD] & ~ev[BTN_RST] & ~ev[BTN_SET];
  assign start_e = ev[BTN_START] & ~ev[BTN_RST] & ~ev[BTN_SET] & ~ev[BTN_LOAD];
  assign div_max = bus.demoOrRealModeIn ? DW'(DEMO_DIV - 1) : DW'(REAL_DIV - 1);
  always_comb begin
    state_n = state;
    set_n   = set_reg;
    count_n = count;
    div_n   = div;
    done_n  = 1'b0;
    if (rst_e) begin
      state_n = IDLE;
      set_n   = '0;
      count_n = '0;
      div_n   = '0;
    end else if (set_e && state != RUN) begin
      state_n = SET;
      set_n   = {clamp9(bus.toggleSwitches17To14In), clamp9(bus.toggleSwitches13To10In)};
    end else if (load_e && state == SET) begin
      state_n = LOADED;
      count_n = set_reg;
    end else if (start_e && state == LOADED) begin
      state_n = count == '0 ? DONE : RUN;
      done_n  = count == '0;
      div_n   = '0;
    end else if (start_e && (state == RUN || state == PAUSE)) begin
      state_n = state == RUN ? PAUSE : RUN;
      div_n   = '0;
    end else if (state == RUN) begin
      if (div >= div_max) begin
        div_n   = '0;
        count_n = bcd_dec(count);
        done_n  = bcd_dec(count) == '0;
        state_n = done_n ? DONE : RUN;
      end else div_n = div + 1'b1;
    end else if (state > DONE) state_n = IDLE;
  end
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state   <= IDLE;
      set_reg <= '0;
      count   <= '0;
      div     <= '0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      set_reg <= set_n;
      count   <= count_n;
      div     <= div_n;
      done    <= done_n;
      running <= state_n == RUN;
    end
  end
  assign bus.countValueOut = count;
  assign bus.stateOut      = state;
  assign bus.runningOut    = running;
  assign bus.doneOut       = done;
endmodule
